alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits.
REQ-002 Parameter: CTRL_W, default 3, ALU control code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  request per requester; bit i held high with operands stable until done[i].
REQ-006 a0, b0  input  WIDTH each  requester-0 operands.
REQ-007 op0  input  CTRL_W  requester-0 ALU control code.
REQ-008 a1, b1  input  WIDTH each  requester-1 operands.
REQ-009 op1  input  CTRL_W  requester-1 ALU control code.
REQ-010 done  output  2  one-hot, one-cycle completion pulse to the served requester.
REQ-011 result  output  WIDTH  captured ALU result; valid while done != 0, held otherwise.
REQ-012 flags  output  4  captured ALU flags; same validity as result.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 alu_a, alu_b  output  WIDTH each  operands to the shared ALU.
REQ-015 alu_ctrl  output  CTRL_W  control code to the shared ALU.
REQ-016 alu_result  input  WIDTH  ALU result; registered in the ALU, valid one cycle after inputs are applied.
REQ-017 alu_flags  input  4  ALU flags; same timing as alu_result.
REQ-018 op_count  output  8  completed-operation counter, saturating.

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, DONE. The sequence is fixed at one cycle per state.
REQ-020 In IDLE with req == 0, the FSM shall remain in IDLE.
REQ-021 In IDLE with any req bit high, the FSM shall grant one requester, latch its a/b/op into operand registers, record the grant and move to ISSUE.
REQ-022 Arbitration: round-robin. If both requests are high, the requester not granted last wins. A single request wins unconditionally.
REQ-023 alu_a, alu_b and alu_ctrl shall be driven from the operand registers. They change only on an IDLE->ISSUE transition and hold between operations.
REQ-024 ISSUE: no output change; the ALU registers its inputs at the end of this cycle; next state CAPTURE.
REQ-025 CAPTURE: sample alu_result and alu_flags into the result/flags registers at the end of the cycle; next state DONE.
REQ-026 DONE: assert done[grant] for exactly this cycle, increment op_count unless it equals 255, then move to IDLE.
REQ-027 Latency: req first sampled high in IDLE at cycle N -> done pulse in cycle N+3. Minimum spacing between grants is 4 cycles.
REQ-028 req is sampled only in IDLE. Changes to req or operands during ISSUE, CAPTURE or DONE shall be ignored.
REQ-029 A req bit still high in the IDLE cycle after its done pulse shall be treated as a new request, subject to round-robin.
REQ-030 op codes shall pass through unchecked; the arbiter performs no arithmetic on them.
REQ-031 op_count saturates at 255 and shall never wrap.

Reset
REQ-032 While reset is high: state = IDLE; done = 0; busy = 0; result = 0; flags = 0; alu_a = alu_b = 0; alu_ctrl = 0; op_count = 0.
REQ-033 On reset, last-grant shall be set to requester 1, so requester 0 wins the first contested arbitration.
REQ-034 Reset asserted mid-operation shall abort the operation with no done pulse and no op_count increment. The aborted requester must re-request.

Structure
REQ-035 A shared package alu_pkg shall hold: the state enum, ALU_CTRL_W = 3, ALU_FLAGS_W = 4, and the requester-id type.
REQ-036 A sub-module rr_arbiter_2 shall implement the two-way round-robin grant and last-grant register. It updates only when the FSM accepts a request in IDLE.
REQ-037 The ALU is external. alu_arbiter shall not instantiate it.

Verification
REQ-038 The bench shall use an ALU stub with a registered add: alu_result = alu_a + alu_b mod 16, flags[0] = carry, one-cycle latency.
REQ-039 Single request: req = 01, a0 = 3, b0 = 4 at cycle N -> done = 01 at N+3, result = 7, busy high for N+1..N+3, op_count = 1.
REQ-040 Contention: req = 11 from reset, a0 = 1, b0 = 1, a1 = 9, b1 = 9 -> done = 01 with result 2 first. Then done = 10 with result 2 and flags[0] = 1, four cycles later.
REQ-041 Persistent contention: both req held high for 8 grants -> the grant order strictly alternates 0,1,0,1,...
REQ-042 Mid-operation reset: assert reset during CAPTURE -> no done pulse; all outputs return to zero immediately (asynchronously); the next req = 10 is served normally.
REQ-043 Operand change: change a0 during ISSUE -> result reflects the operands latched at grant.
REQ-044 Saturation: complete 260 operations -> op_count = 255 and stays at 255.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: FSM state enum, ALU control/flag widths and requester id shared by alu_arbiter and rr_arbiter_2
package alu_pkg;
  localparam int ALU_CTRL_W = 3;
  localparam int ALU_FLAGS_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  typedef logic req_id_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant (clk, reset, req[1:0], accept in; grant out), last grant recorded only on accept
module rr_arbiter_2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output req_id_t    grant
);
  req_id_t last;
  assign grant = &req ? ~last : req[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= 1'b1;
    else if (accept) last <= grant;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered external ALU between two requesters (req/a/b/op in; done/result/flags/busy/op_count out; alu_a/alu_b/alu_ctrl to ALU, alu_result/alu_flags back)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [WIDTH-1:0]       a0,
  input  logic [WIDTH-1:0]       b0,
  input  logic [CTRL_W-1:0]      op0,
  input  logic [WIDTH-1:0]       a1,
  input  logic [WIDTH-1:0]       b1,
  input  logic [CTRL_W-1:0]      op1,
  output logic [1:0]             done,
  output logic [WIDTH-1:0]       result,
  output logic [ALU_FLAGS_W-1:0] flags,
  output logic                   busy,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [CTRL_W-1:0]      alu_ctrl,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [ALU_FLAGS_W-1:0] alu_flags,
  output logic [7:0]             op_count
);
  state_t  state, state_nx;
  req_id_t grant, owner;
  logic    accept;
  assign accept = state == IDLE && |req;
  rr_arbiter_2 u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .accept(accept),
    .grant(grant)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    busy = 1'b0;
    done = 2'b00;
    state_nx = state == IDLE ? (accept ? ISSUE : IDLE) :
               state == ISSUE ? CAPTURE :
               state == CAPTURE ? DONE : IDLE;
    busy = state != IDLE;
    done = state == DONE ? (owner ? 2'b10 : 2'b01) : 2'b00;
  end
  // operand registers double as the ALU drive, so they only move on a grant
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      result <= '0;
      flags <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        owner <= grant;
        alu_a <= grant ? a1 : a0;
        alu_b <= grant ? b1 : b0;
        alu_ctrl <= grant ? op1 : op0;
      end
      if (state == CAPTURE) begin
        result <= alu_result;
        flags <= alu_flags;
      end
      if (state == DONE && op_count != 8'hff) op_count <= op_count + 8'd1;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter with a registered-add ALU stub
module tb_alu_arbiter;
  localparam int W = 4;
  localparam int C = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [C-1:0] op0 = '0, op1 = '0;
  logic [1:0] done;
  logic [W-1:0] result, alu_a, alu_b, alu_result;
  logic [3:0] flags, alu_flags;
  logic busy;
  logic [C-1:0] alu_ctrl;
  logic [7:0] op_count;
  logic [4:0] sum;
  int pass = 0, total = 0;
  bit m_last;
  int m_count;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .CTRL_W(C)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .done(done), .result(result), .flags(flags), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags), .op_count(op_count)
  );

  always @(posedge clk) sum <= {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = sum[3:0];
  assign alu_flags = {3'b000, sum[4]};

  function automatic bit pick(logic [1:0] r);
    return (r == 2'b11) ? !m_last : r[1];
  endfunction

  function automatic int sat(int n);
    return n > 255 ? 255 : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n, output logic [1:0] d);
    n = 0;
    do begin
      tick();
      n++;
    end while (done == 2'b00 && n < 8);
    d = done;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    m_last = 1'b1;
    m_count = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    total++; if ({done, busy} !== 3'b000) $display("FAIL reset_ctl got done=%b busy=%b want 00/0", done, busy); else pass++;
    total++; if ({result, flags} !== 8'h00) $display("FAIL reset_res got result=%h flags=%h want 0/0", result, flags); else pass++;
    total++; if ({alu_a, alu_b, alu_ctrl} !== 11'h000) $display("FAIL reset_alu got a=%h b=%h ctrl=%h want 0", alu_a, alu_b, alu_ctrl); else pass++;
    total++; if (op_count !== 8'd0) $display("FAIL reset_cnt got %0d want 0", op_count); else pass++;
    req = 2'b11;
    tick();
    tick();
    total++; if ({done, busy} !== 3'b000) $display("FAIL reset_held got done=%b busy=%b want 00/0", done, busy); else pass++;
    req = 2'b00;
    reset = 1'b0;
    m_last = 1'b1;
    m_count = 0;
  endtask

  task automatic test_single();
    logic [C-1:0] op;
    op = C'($urandom);
    a0 = 4'd3; b0 = 4'd4; op0 = op; req = 2'b01;
    tick();
    total++; if ({busy, done} !== 3'b100) $display("FAIL single_n1 got busy=%b done=%b want 1/00", busy, done); else pass++;
    total++; if ({alu_a, alu_b, alu_ctrl} !== {4'd3, 4'd4, op}) $display("FAIL single_alu got a=%h b=%h ctrl=%h want 3/4/%h", alu_a, alu_b, alu_ctrl, op); else pass++;
    req = 2'b00;
    a0 = 4'($urandom);
    tick();
    total++; if ({busy, done} !== 3'b100) $display("FAIL single_n2 got busy=%b done=%b want 1/00", busy, done); else pass++;
    tick();
    total++; if ({busy, done} !== 3'b101) $display("FAIL single_n3 got busy=%b done=%b want 1/01", busy, done); else pass++;
    total++; if ({result, flags} !== {4'd7, 4'd0}) $display("FAIL single_res got result=%0d flags=%b want 7/0000", result, flags); else pass++;
    m_last = 1'b0; m_count++;
    tick();
    total++; if ({busy, done} !== 3'b000) $display("FAIL single_n4 got busy=%b done=%b want 0/00", busy, done); else pass++;
    total++; if (op_count !== 8'(sat(m_count))) $display("FAIL single_cnt got %0d want %0d", op_count, sat(m_count)); else pass++;
  endtask

  task automatic test_contention();
    int n;
    logic [1:0] d;
    do_reset();
    a0 = 4'd1; b0 = 4'd1; a1 = 4'd9; b1 = 4'd9; req = 2'b11;
    wait_done(n, d);
    total++; if (d !== 2'b01 || n != 3) $display("FAIL cont_first got done=%b after %0d want 01 after 3", d, n); else pass++;
    total++; if ({result, flags} !== {4'd2, 4'd0}) $display("FAIL cont_first_res got %0d/%b want 2/0000", result, flags); else pass++;
    m_last = 1'b0; m_count++;
    wait_done(n, d);
    total++; if (d !== 2'b10 || n != 4) $display("FAIL cont_second got done=%b after %0d want 10 after 4", d, n); else pass++;
    total++; if ({result, flags} !== {4'd2, 4'd1}) $display("FAIL cont_second_res got %0d/%b want 2/0001", result, flags); else pass++;
    m_last = 1'b1; m_count++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    int n, s;
    bit g;
    logic [1:0] d;
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    op0 = C'($urandom); op1 = C'($urandom);
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      g = pick(2'b11);
      s = g ? int'(a1) + int'(b1) : int'(a0) + int'(b0);
      wait_done(n, d);
      total++; if (d !== (g ? 2'b10 : 2'b01)) $display("FAIL rr_order[%0d] got %b want %b", i, d, g ? 2'b10 : 2'b01); else pass++;
      total++; if (n != (i == 0 ? 3 : 4)) $display("FAIL rr_spacing[%0d] got %0d want %0d", i, n, i == 0 ? 3 : 4); else pass++;
      total++; if (int'(result) != s % 16 || int'(flags) != s / 16) $display("FAIL rr_result[%0d] got %0d/%b want %0d/%0d", i, result, flags, s % 16, s / 16); else pass++;
      m_last = g; m_count++;
      if (g) begin a1 = 4'($urandom); b1 = 4'($urandom); end
      else begin a0 = 4'($urandom); b0 = 4'($urandom); end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_operand_change();
    int n, s;
    logic [1:0] d;
    logic [W-1:0] la;
    for (int r = 0; r < 2; r++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      req = r == 1 ? 2'b10 : 2'b01;
      la = r == 1 ? a1 : a0;
      s = r == 1 ? int'(a1) + int'(b1) : int'(a0) + int'(b0);
      tick();
      a0 = ~a0; b0 = b0 + 4'd5; a1 = ~a1; b1 = b1 + 4'd3; op0 = ~op0; op1 = ~op1;
      req = 2'b00;
      wait_done(n, d);
      total++; if (d !== (r == 1 ? 2'b10 : 2'b01) || n != 2) $display("FAIL opchg_done[%0d] got %b after %0d want one-hot %0d after 2", r, d, n, r); else pass++;
      total++; if (int'(result) != s % 16 || int'(flags) != s / 16) $display("FAIL opchg_res[%0d] got %0d/%b want %0d/%0d", r, result, flags, s % 16, s / 16); else pass++;
      total++; if (alu_a !== la) $display("FAIL opchg_alu_a[%0d] got %h want %h", r, alu_a, la); else pass++;
      m_last = r[0]; m_count++;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int n, s;
    logic [1:0] d;
    a0 = 4'(1 + $urandom_range(14)); b0 = 4'($urandom); req = 2'b01;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    total++; if ({done, busy} !== 3'b000) $display("FAIL mrst_ctl got done=%b busy=%b want 00/0", done, busy); else pass++;
    total++; if ({alu_a, alu_b, alu_ctrl, result, flags} !== 19'h0) $display("FAIL mrst_data got a=%h b=%h ctrl=%h res=%h fl=%h want 0", alu_a, alu_b, alu_ctrl, result, flags); else pass++;
    total++; if (op_count !== 8'd0) $display("FAIL mrst_cnt got %0d want 0", op_count); else pass++;
    req = 2'b00;
    tick();
    total++; if (done !== 2'b00) $display("FAIL mrst_nodone got %b want 00", done); else pass++;
    tick();
    reset = 1'b0;
    m_last = 1'b1; m_count = 0;
    a1 = 4'($urandom); b1 = 4'($urandom); req = 2'b10;
    s = int'(a1) + int'(b1);
    wait_done(n, d);
    total++; if (d !== 2'b10 || n != 3) $display("FAIL mrst_next got %b after %0d want 10 after 3", d, n); else pass++;
    total++; if (int'(result) != s % 16 || int'(flags) != s / 16) $display("FAIL mrst_res got %0d/%b want %0d/%0d", result, flags, s % 16, s / 16); else pass++;
    req = 2'b00;
    m_last = 1'b1; m_count++;
    tick();
    total++; if (op_count !== 8'(sat(m_count))) $display("FAIL mrst_cnt_after got %0d want %0d", op_count, sat(m_count)); else pass++;
  endtask

  task automatic test_saturation();
    int n;
    logic [1:0] d;
    a0 = 4'($urandom); b0 = 4'($urandom); req = 2'b01;
    for (int i = 0; i < 260; i++) begin
      wait_done(n, d);
      total++; if (d !== 2'b01 || op_count !== 8'(sat(m_count))) $display("FAIL sat_step[%0d] got done=%b cnt=%0d want 01/%0d", i, d, op_count, sat(m_count)); else pass++;
      m_last = 1'b0; m_count++;
    end
    req = 2'b00;
    tick();
    total++; if (op_count !== 8'd255) $display("FAIL sat_final got %0d want 255", op_count); else pass++;
    repeat (5) tick();
    total++; if (op_count !== 8'd255) $display("FAIL sat_hold got %0d want 255", op_count); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_operand_change();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
